// File: rtl/d_cache_pkg.sv
// Shared D-cache constants, controller state encoding and address field helpers.
package d_cache_pkg;

    localparam int TAG_W = 55;
    localparam int IDX_W = 6;
    localparam int OFF_W = 3;

    localparam logic [63:0] LINE_ADDR_MASK = 64'hFFFF_FFFF_FFFF_FFF8;

    typedef enum logic [2:0] {
        ST_FLUSH  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_REFILL = 3'd3,
        ST_WRITE  = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [63:0] addr);
        return addr[63:OFF_W+IDX_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [63:0] addr);
        return addr[OFF_W+IDX_W-1:OFF_W];
    endfunction

endpackage

// File: rtl/d_cache_tag_ctrl.sv
// Tag-array controller for the direct-mapped D-cache: lookup, miss refill,
// tag write and a full invalidate sweep after reset or on flush_req.
//
// state  | meaning
// -------+---------------------------------------------------------------
// FLUSH  | write {valid=0, tag=0} to set fidx, 0..63, one set per cycle
// IDLE   | accept a lookup; tag RAM read addressed straight from req_addr
// LOOKUP | tag RAM data available, compare against latched address
// REFILL | refill request held until refill_ack
// WRITE  | write {1, tag} of the refilled line
// RESP   | one-cycle response pulse
module d_cache_tag_ctrl
    import d_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [63:0]       req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              refill_req_valid,
    output logic [63:0]       refill_addr,
    input  logic              refill_ack,
    input  logic              flush_req,
    output logic              flush_done,
    output logic [IDX_W-1:0]  tag_addr,
    output logic [TAG_W:0]    tag_wdata,
    output logic              tag_we,
    input  logic [TAG_W-1:0]  tag_rdata,
    input  logic              tag_rvalid
);

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  fidx;
    logic [63:0]       lat_addr;
    logic              hit;

    assign hit         = tag_rvalid && (tag_rdata == addr_tag(lat_addr));
    assign refill_addr = lat_addr & LINE_ADDR_MASK;

    // Next-state decode and tag RAM / handshake drive.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        tag_we     = 1'b0;
        tag_addr   = addr_idx(lat_addr);
        tag_wdata  = '0;
        case (state)
            ST_FLUSH: begin
                tag_we   = 1'b1;
                tag_addr = fidx;
                if (fidx == '1) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // Read is issued speculatively so the data lands in LOOKUP.
                tag_addr = addr_idx(req_addr);
                if (flush_req) begin
                    state_next = ST_FLUSH;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        state_next = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                state_next = hit ? ST_RESP : ST_REFILL;
            end
            ST_REFILL: begin
                if (refill_ack && refill_req_valid) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                tag_we     = 1'b1;
                tag_wdata  = {1'b1, addr_tag(lat_addr)};
                state_next = ST_RESP;
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_FLUSH;
            end
        endcase
    end

    // State, sweep counter, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_FLUSH;
            fidx             <= '0;
            lat_addr         <= '0;
            resp_valid       <= 1'b0;
            resp_hit         <= 1'b0;
            refill_req_valid <= 1'b0;
            flush_done       <= 1'b0;
        end else begin
            state            <= state_next;
            fidx             <= (state == ST_FLUSH) ? fidx + 6'd1 : '0;
            if (req_valid && req_ready) begin
                lat_addr <= req_addr;
            end
            resp_valid       <= (state_next == ST_RESP);
            resp_hit         <= (state == ST_LOOKUP) && hit;
            refill_req_valid <= (state_next == ST_REFILL);
            flush_done       <= (state == ST_FLUSH) && (fidx == '1);
        end
    end

endmodule

// File: doc/d_cache_tag_ctrl.md
# d_cache_tag_ctrl

Requester-side controller for the direct-mapped 64-set D-cache tag array (`d_cache_tag_ram`: 1-cycle read latency, 56-bit entries {valid, tag[54:0]}). It accepts lookup requests from the LSU, reads and compares the tag, and on a miss issues a line-refill request and writes the new tag. After reset it sweeps all 64 sets invalid. It sits between the LSU/cache datapath and the tag RAM; the parent instantiates both blocks.

## Interface
Parameters:
- TAG_W, 55, tag width; address bits [63:9]
- IDX_W, 6, set index width; address bits [8:3]
- OFF_W, 3, byte offset within an 8-byte line; address bits [2:0]

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  lookup request
- req_addr  in  64  lookup byte address
- req_ready  out  1  request accepted when req_valid && req_ready
- resp_valid  out  1  one-cycle response pulse
- resp_hit  out  1  1 = hit, 0 = miss (already refilled); valid with resp_valid
- refill_req_valid  out  1  line refill request, held until acked
- refill_addr  out  64  line address: req_addr with [2:0] = 0
- refill_ack  in  1  refill complete; sampled only while refill_req_valid = 1
- flush_req  in  1  invalidate all sets (one-cycle pulse, sampled in IDLE)
- flush_done  out  1  one-cycle pulse at end of a sweep
- tag_addr  out  6  tag RAM set index
- tag_wdata  out  56  {valid, tag} write data
- tag_we  out  1  tag RAM write enable
- tag_rdata  in  55  tag RAM read tag
- tag_rvalid  in  1  tag RAM read valid bit

## Operation
States: FLUSH, IDLE, LOOKUP, REFILL, WRITE, RESP.
- FLUSH: 6-bit counter `fidx` 0→63. Each cycle: tag_we=1, tag_addr=fidx, tag_wdata=0. After fidx=63 → IDLE and pulse flush_done.
- IDLE: req_ready=1. flush_req has priority: if asserted, req_ready=0, enter FLUSH with fidx=0. Otherwise tag_addr=req_addr[8:3] combinationally, tag_we=0. On handshake, latch the address → LOOKUP.
- LOOKUP: hit = tag_rvalid && tag_rdata == lat_addr[63:9]. Hit → RESP with resp_hit registered 1. Miss → REFILL.
- REFILL: refill_req_valid=1, refill_addr={lat_addr[63:3],3'b0}. On refill_ack → WRITE.
- WRITE: tag_we=1, tag_addr=lat_addr[8:3], tag_wdata={1'b1, lat_addr[63:9]}. → RESP with resp_hit=0.
- RESP: resp_valid=1 for one cycle → IDLE.
- tag_we=0 in every state except FLUSH and WRITE.
- flush_req outside IDLE is ignored, not queued.
- Reset: state=FLUSH, fidx=0. All registered outputs are 0: resp_valid, resp_hit, refill_req_valid, flush_done, req_ready. Reset during REFILL abandons the refill; a late refill_ack is ignored. The tag RAM has no reset, so the post-reset sweep is mandatory.

## Timing
- Reset deasserted at edge E0. Write cycles occur at E0..E63. flush_done=1 and req_ready=1 in the cycle after E63.
- Hit latency: handshake at cycle 0, compare in cycle 1, resp_valid in cycle 2. The next request can be accepted in cycle 3.
- Miss latency: refill_req_valid from cycle 2. With refill_ack in cycle k: WRITE in cycle k+1, resp_valid in k+2, IDLE in k+3.
- refill_ack in the same cycle refill_req_valid rises is legal.
- A back-to-back lookup of the same set right after a WRITE reads the new tag; RAM write-then-read ordering is guaranteed by the state sequence.

## Structure
- Shared package `d_cache_pkg`: TAG_W, IDX_W, OFF_W, LINE_ADDR_MASK, the state enum, and a field-extraction helper (tag/index of a 64-bit address). Used also by the data-array controller.
- No sub-module; the flush counter and comparator are inline. The tag RAM stays external.

## Test plan
- Reset, then observe: 64 writes of 0 to sets 0..63 in order; flush_done one pulse in cycle 64; req_ready rises in the same cycle.
- Cold miss on 0x1008 (set 1, tag 0x8): refill_addr=0x1008; ack after 3 cycles; then one write of {1,0x8} to set 1; resp_hit=0.
- Re-lookup of 0x100C: hit, resp_valid in cycle 2, no refill request.
- Alias 0x2008 (set 1, tag 0x10): miss and set 1 is rewritten. A following lookup of 0x1008 misses again.
- flush_req in IDLE after filling sets 1 and 5: 64-cycle sweep, flush_done pulse, then 0x1008 misses.
- Reset asserted mid-REFILL with a later refill_ack: refill_req_valid drops, the ack is ignored, a full sweep runs, and no resp_valid is produced.
